// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter: FSM state encoding,
// the default burst length and the width of the beat counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_DMA  = 2'd1,
        ST_FAIR = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_BURST_DEFAULT = 8;
    localparam int unsigned CNT_W             = 8;

endpackage

// File: rtl/mem_arb.sv
// mem_arb: arbitrates one synchronous memory port between a CPU core and a
// DMA engine. The core is granted the bus by default; DMA takes it only at an
// instruction boundary (sync) and gives it back after MAX_BURST beats or when
// dma_req drops. After each burst the FAIR state lets the core run at least
// one full instruction before the next grant.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   sync                    core opcode-fetch cycle flag
//   cpu_ab/cpu_we/cpu_do    core address / write enable / write data
//   cpu_di, cpu_ce          read data to core, core clock enable
//   dma_req                 DMA level request
//   dma_ab/dma_we/dma_do    DMA address / write enable / write data
//   dma_gnt, dma_ack        bus owned by DMA, beat accepted this cycle
//   dma_di, dma_rvalid      DMA read data, valid one cycle after a read beat
//   mem_ab/mem_we/mem_do    memory port (read data returns next cycle)
//   mem_di                  memory read data
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    output logic        cpu_ce,
    input  logic        dma_req,
    input  logic [15:0] dma_ab,
    input  logic        dma_we,
    input  logic [7:0]  dma_do,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  dma_di,
    output logic        dma_rvalid,
    output logic [15:0] mem_ab,
    output logic        mem_we,
    output logic [7:0]  mem_do,
    input  logic [7:0]  mem_di
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [7:0]       hold_reg;
    logic             resume;
    logic             beat;

    always_comb begin
        beat = (state == ST_DMA) && dma_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CPU;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_CPU: begin
                if (sync && dma_req) begin
                    state_next = ST_DMA;
                end
            end
            ST_DMA: begin
                if (!dma_req || (count == LAST_BEAT)) begin
                    state_next = ST_FAIR;
                end
            end
            ST_FAIR: begin
                if (sync) begin
                    state_next = ST_CPU;
                end
            end
            default: state_next = ST_CPU;
        endcase
    end

    // Output decode and datapath muxes
    always_comb begin
        cpu_ce  = 1'b1;
        dma_gnt = 1'b0;
        dma_ack = 1'b0;
        mem_ab  = cpu_ab;
        mem_we  = cpu_we;
        mem_do  = cpu_do;
        if (state == ST_DMA) begin
            cpu_ce  = 1'b0;
            dma_gnt = 1'b1;
            dma_ack = dma_req;
            mem_ab  = dma_ab;
            mem_we  = dma_we & dma_req;
            mem_do  = dma_do;
        end
        // The core's frozen read and its first enabled cycle see the byte
        // that was in flight when the grant took effect.
        cpu_di = ((state == ST_DMA) || resume) ? hold_reg : mem_di;
        dma_di = mem_di;
    end

    // Beat counter, held core data, resume flag and read-valid pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            hold_reg   <= '0;
            resume     <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= beat & ~dma_we;
            resume     <= (state == ST_DMA) && (state_next != ST_DMA);
            if ((state != ST_DMA) && (state_next == ST_DMA)) begin
                count <= '0;
            end else if (beat) begin
                count <= count + 1'b1;
            end
            // count is zero only in the first DMA cycle: any cycle without
            // a beat leaves DMA, and every beat advances the counter.
            if ((state == ST_DMA) && (count == '0)) begin
                hold_reg <= mem_di;
            end
        end
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: MAX_BURST, 8, maximum DMA beats per grant (legal range 1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: sync  in  1  core instruction-boundary flag (opcode fetch cycle).
REQ-005 Port: cpu_ab / cpu_we / cpu_do  in  16/1/8  core address, write enable and write data.
REQ-006 Port: cpu_di  out  8  read data returned to the core.
REQ-007 Port: cpu_ce  out  1  core clock enable; 0 freezes the core.
REQ-008 Port: dma_req  in  1  level request; a beat is issued each DMA cycle it stays high.
REQ-009 Port: dma_ab / dma_we / dma_do  in  16/1/8  DMA address, write enable and write data.
REQ-010 Port: dma_gnt / dma_ack  out  1/1  bus owned by DMA / beat accepted this cycle.
REQ-011 Port: dma_di / dma_rvalid  out  8/1  DMA read data, valid one cycle after a read beat.
REQ-012 Port: mem_ab / mem_we / mem_do  out  16/1/8  synchronous memory port; read data arrives next cycle.
REQ-013 Port: mem_di  in  8  memory read data.

Function
REQ-014 The FSM SHALL have states CPU, DMA and FAIR.
REQ-015 CPU: cpu_ce=1 and mem_* = cpu_*.
REQ-016 DMA: cpu_ce=0, dma_gnt=1 and mem_* = dma_*, with mem_we = dma_we & dma_req.
REQ-017 FAIR: same outputs as CPU; no grant is possible.
REQ-018 CPU->DMA SHALL occur only at the end of a cycle with sync=1 and dma_req=1; grant latency is 1 cycle after that sync cycle.
REQ-019 In DMA, each cycle with dma_req=1 is a beat: dma_ack=1 and the beat counter increments.
REQ-020 DMA->FAIR SHALL occur on the beat where count==MAX_BURST-1, or on any DMA cycle with dma_req=0; that cycle carries no beat and mem_we=0.
REQ-021 FAIR->CPU SHALL occur at the end of the first sync=1 cycle seen in FAIR, which guarantees one full instruction between bursts.
REQ-022 dma_rvalid SHALL be 1 exactly one cycle after each beat with dma_we=0; dma_di = mem_di.
REQ-023 hold_reg SHALL capture mem_di in the first DMA cycle (the core's pending read data).
REQ-024 cpu_di SHALL equal hold_reg in the DMA cycles and in the first cpu_ce=1 cycle after DMA; otherwise cpu_di = mem_di.
REQ-025 The beat counter SHALL clear on entry to DMA and SHALL never wrap.
REQ-026 A core write (cpu_we=1) in the sync cycle SHALL reach memory unchanged; the grant takes effect only from the next cycle.
REQ-027 With MAX_BURST=1, each grant SHALL yield exactly one beat and then FAIR.

Reset
REQ-028 Reset SHALL force: state CPU, cpu_ce=1, dma_gnt=0, dma_ack=0, dma_rvalid=0, counter 0, hold_reg 0, resume flag 0.
REQ-029 Reset during DMA SHALL abort the burst in the same edge, with no further beat or memory write.
REQ-030 Reset SHALL take priority over every transition.

Structure
REQ-031 State encodings and the MAX_BURST default SHALL live in shared package mem_arb_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the datapath muxes and FSM stay together.

Verification
REQ-033 No dma_req, run NOP loop -> cpu_ce constantly 1, mem_ab tracks cpu_ab, dma_gnt never 1.
REQ-034 dma_req held high, MAX_BURST=8, reads $0200..$0207 -> exactly 8 dma_ack.
  - Grant follows the sync cycle.
  - 8 dma_rvalid with data matching memory.
  - FAIR until the next sync.
REQ-035 Opcode fetch at $1000 (mem $A9) in the sync cycle, burst granted -> after release the core's first enabled cycle sees cpu_di=$A9.
REQ-036 dma_req drops after 3 beats of writes $55 to $0300.. -> 3 mem_we pulses and FAIR, with no write in the drop cycle.
REQ-037 Reset asserted on the 2nd beat -> next cycle state CPU, cpu_ce=1, no further mem_we from DMA.
REQ-038 dma_req high continuously across two instructions -> one full core instruction (sync to sync) executes between the two bursts.
